// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//
// Byte-stream memory loader. A frame arrives as ADDR_HI, ADDR_LO, LEN_HI,
// LEN_LO, followed by LEN 16-bit words sent high byte first. Each word is
// written to the target memory one cycle after its low byte is accepted,
// at consecutive addresses starting at ADDR. A frame that would run past the
// end of the memory is rejected up front, and the loader then sits in a
// sticky error state, swallowing bytes, until reset.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   in_data   byte-stream data
//   in_valid  in_data is valid
//   in_ready  loader accepts a byte this cycle (low during rst and writes)
//   w_addr    memory write address (holds between writes)
//   w_data    memory write data (holds between writes)
//   w_en      one-cycle write strobe per word
//   busy      frame in progress; the CPU must be held off the memory
//   done      one-cycle pulse when a frame completes
//   err       sticky range error
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter int N_ELEMENTS = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [7:0]            data_hi_q, data_hi_d;
    logic [15:0]           ptr_q, ptr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic [15:0]           len_word;
    logic [16:0]           frame_end;

    // A byte moves only on a valid/ready handshake. in_ready is forced low
    // while rst is high so nothing is taken during reset, and low in the
    // write cycle so the stream stalls while the word goes out.
    assign in_ready = !rst && (state_q != S_WRITE);
    assign accept   = in_valid && in_ready;

    // Frame range check is done in 17 bits so ADDR+LEN cannot overflow and
    // slip past the comparison.
    assign len_word  = {len_hi_q, in_data};
    assign frame_end = {1'b0, ptr_q} + {1'b0, len_word};

    // The strobe is gated by rst so a reset landing on the write cycle
    // suppresses that write as well.
    assign w_en   = (state_q == S_WRITE) && !rst;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;
    assign busy   = (state_q != S_ADDR_HI) && (state_q != S_ERR);
    assign err    = (state_q == S_ERR);
    assign done   = done_q;

    // State register and datapath flops; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ADDR_HI;
            addr_hi_q <= '0;
            len_hi_q  <= '0;
            data_hi_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            len_hi_q  <= len_hi_d;
            data_hi_q <= data_hi_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath logic. Byte states advance only on accept, so
    // a stalled stream leaves everything untouched. The pointer is loaded
    // from the address bytes and is the write address for each word; the
    // count is loaded from the length bytes and runs down to zero.
    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        len_hi_d  = len_hi_q;
        data_hi_d = data_hi_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        done_d    = 1'b0;

        case (state_q)
            S_ADDR_HI: begin
                if (accept) begin
                    addr_hi_d = in_data;
                    state_d   = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (accept) begin
                    ptr_d   = {addr_hi_q, in_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                // Range error takes precedence over the empty-frame case.
                if (accept) begin
                    cnt_d = len_word;
                    if (frame_end > 17'(N_ELEMENTS)) begin
                        state_d = S_ERR;
                    end else if (len_word == 16'd0) begin
                        state_d = S_ADDR_HI;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    data_hi_d = in_data;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // Address and data are captured here so they are already
                // stable on the strobe cycle and simply hold afterwards.
                if (accept) begin
                    w_data_d = DATA_WIDTH'({data_hi_q, in_data});
                    w_addr_d = ADDR_WIDTH'(ptr_q);
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                ptr_d = ptr_q + 16'd1;
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = S_ADDR_HI;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ADDR_HI;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
//
// Directed bench for mem_loader. A frame-level model tracks the accepted
// byte stream by position within the frame and predicts, for every cycle,
// the strobe, address, data, ready, busy, done and err outputs. A negedge
// process compares the DUT against it each cycle and builds a shadow memory
// from the DUT's writes; directed tests then pin the model with literal
// expectations on memory contents and cycle spacing.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    localparam int N = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        w_en;
    logic        busy;
    logic        done;
    logic        err;

    mem_loader #(.N_ELEMENTS(N), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_en     (w_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    // Frame model state
    int          pos = 0;
    int          m_addr = 0;
    int          m_len = 0;
    int          words = 0;
    bit          m_err = 1'b0;
    bit          m_write = 1'b0;
    bit          m_done = 1'b0;
    logic [7:0]  hdr [4];
    logic [7:0]  hi_byte = 8'h00;
    logic [15:0] exp_addr = 16'h0000;
    logic [15:0] exp_data = 16'h0000;

    // Values sampled on the negedge for the model's next update
    bit          s_rst = 1'b1;
    bit          s_acc = 1'b0;
    logic [7:0]  s_data = 8'h00;

    // Observations of the DUT
    logic [15:0] shadow [N];
    int          write_count = 0;
    int          done_count = 0;
    int          done_cycle = 0;
    int          w_cycles [$];
    logic [7:0]  tx_q [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: position counts bytes accepted in the current frame; the
    // header sits at positions 0..3 and word k occupies positions 4+2k and
    // 5+2k. The low byte of a word schedules a write for the following
    // cycle, during which the stream is stalled.
    always @(posedge clk) begin
        cyc++;
        if (s_rst) begin
            pos      = 0;
            m_addr   = 0;
            m_len    = 0;
            words    = 0;
            m_err    = 1'b0;
            m_write  = 1'b0;
            m_done   = 1'b0;
            exp_addr = 16'h0000;
            exp_data = 16'h0000;
        end else begin
            m_done = 1'b0;
            if (m_write) begin
                m_write = 1'b0;
                words++;
                if (words == m_len) begin
                    pos    = 0;
                    m_done = 1'b1;
                end
            end else if (!m_err && s_acc) begin
                if (pos < 4) begin
                    hdr[pos] = s_data;
                end else if (((pos - 4) % 2) == 0) begin
                    hi_byte = s_data;
                end else begin
                    m_write  = 1'b1;
                    exp_addr = 16'(m_addr + words);
                    exp_data = {hi_byte, s_data};
                end
                pos++;
                if (pos == 4) begin
                    m_addr = {hdr[0], hdr[1]};
                    m_len  = {hdr[2], hdr[3]};
                    words  = 0;
                    if (m_addr + m_len > N) begin
                        m_err = 1'b1;
                    end else if (m_len == 0) begin
                        pos    = 0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, then sample handshake inputs.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("in_ready", in_ready, !rst && !m_write);
            checkOutput("w_en", w_en, m_write && !rst);
            checkOutput("w_addr", w_addr, exp_addr);
            checkOutput("w_data", w_data, exp_data);
            checkOutput("busy", busy, (pos != 0) && !m_err);
            checkOutput("done", done, m_done);
            checkOutput("err", err, m_err);
            if (w_en === 1'b1) begin
                checks++;
                if (w_addr >= 16'(N)) begin
                    errors++;
                    $display("[TB] FAIL ptr_wrap: w_addr %0h limit %0h", w_addr, N);
                end else begin
                    shadow[w_addr[6:0]] = w_data;
                end
                write_count++;
                w_cycles.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_count++;
                done_cycle = cyc;
            end
        end
        s_rst  = rst;
        s_acc  = in_valid && !rst && !m_write;
        s_data = in_data;
    end

    // Sends tx_q with a real valid/ready handshake; in toggle mode in_valid
    // alternates every cycle regardless of acceptance.
    task automatic applyStimulus(input bit toggle);
        int idx = 0;
        int budget = 0;
        bit phase = 1'b1;
        while (idx < tx_q.size() && budget < 200) begin
            in_valid = toggle ? phase : 1'b1;
            in_data  = tx_q[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            phase = !phase;
            budget++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        checkOutput("stream_consumed", idx, tx_q.size());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int wc0;
    int dc0;

    initial begin
        for (int i = 0; i < N; i++) shadow[i] = 16'h0000;

        // Reset values, including in_ready held low during rst
        @(posedge clk);
        #1;
        started = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_w_addr", w_addr, 0);
        checkOutput("rst_w_data", w_data, 0);
        checkOutput("rst_w_en", w_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal three-word load at address 0, in_valid held high
        $display("[TB] nominal load");
        wc0 = write_count; dc0 = done_count; w_cycles.delete();
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h20, 8'h12, 8'h22, 8'h12, 8'hF0, 8'h00};
        applyStimulus(1'b0);
        idle(4);
        checkOutput("nom_writes", write_count - wc0, 3);
        checkOutput("nom_mem0", shadow[0], 16'h2012);
        checkOutput("nom_mem1", shadow[1], 16'h2212);
        checkOutput("nom_mem2", shadow[2], 16'hF000);
        checkOutput("nom_done_cnt", done_count - dc0, 1);
        if (w_cycles.size() == 3) begin
            checkOutput("nom_period01", w_cycles[1] - w_cycles[0], 3);
            checkOutput("nom_period12", w_cycles[2] - w_cycles[1], 3);
            checkOutput("nom_done_lat", done_cycle - w_cycles[2], 1);
        end

        // Offset load ending exactly at the last word, with in_valid toggling
        $display("[TB] offset and backpressure");
        wc0 = write_count; dc0 = done_count;
        tx_q = '{8'h00, 8'h7E, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        applyStimulus(1'b1);
        idle(4);
        checkOutput("bp_writes", write_count - wc0, 2);
        checkOutput("bp_mem7e", shadow[7'h7E], 16'hAABB);
        checkOutput("bp_mem7f", shadow[7'h7F], 16'hCCDD);
        checkOutput("bp_done_cnt", done_count - dc0, 1);

        // Zero-length frame followed directly by a normal one-word frame
        $display("[TB] zero length");
        wc0 = write_count; dc0 = done_count;
        tx_q = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h12, 8'h34};
        applyStimulus(1'b0);
        idle(4);
        checkOutput("zl_writes", write_count - wc0, 1);
        checkOutput("zl_done_cnt", done_count - dc0, 2);
        checkOutput("zl_mem10", shadow[7'h10], 16'h0000);
        checkOutput("zl_mem05", shadow[7'h05], 16'h1234);

        // Reset on the cycle the low byte of word 2 is presented
        $display("[TB] reset mid-frame");
        wc0 = write_count;
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h11, 8'h22};
        applyStimulus(1'b0);
        in_valid = 1'b1;
        in_data  = 8'h22;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("mr_w_addr", w_addr, 0);
        checkOutput("mr_w_data", w_data, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_err", err, 0);
        idle(3);
        checkOutput("mr_writes", write_count - wc0, 1);
        checkOutput("mr_mem0", shadow[0], 16'h1111);
        checkOutput("mr_mem1", shadow[1], 16'h2212);
        tx_q = '{8'h00, 8'h40, 8'h00, 8'h01, 8'hBE, 8'hEF};
        applyStimulus(1'b0);
        idle(3);
        checkOutput("mr_mem40", shadow[7'h40], 16'hBEEF);

        // Range error: 0x7F + 2 overruns the memory; payload is swallowed
        $display("[TB] range error");
        wc0 = write_count;
        tx_q = '{8'h00, 8'h7F, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(1'b0);
        idle(5);
        @(negedge clk);
        checkOutput("re_err", err, 1);
        checkOutput("re_busy", busy, 0);
        checkOutput("re_in_ready", in_ready, 1);
        checkOutput("re_writes", write_count - wc0, 0);
        checkOutput("re_mem7f", shadow[7'h7F], 16'hCCDD);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("re_err_cleared", err, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `rst`.
REQ-002 Parameters SHALL be:
- N_ELEMENTS, 128, number of words in the target memory.
- ADDR_WIDTH, 16, width of the memory address.
- DATA_WIDTH, 16, memory word width; fixed at 16.

REQ-003 Ports, in order, SHALL be:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  8  byte-stream data.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- w_addr  output  ADDR_WIDTH  memory write address.
- w_data  output  DATA_WIDTH  memory write data.
- w_en  output  1  memory write strobe, one cycle per word.
- busy  output  1  frame in progress; CPU must be held.
- done  output  1  one-cycle pulse when a frame completes.
- err  output  1  sticky range error.

Function
REQ-004 A byte SHALL be accepted exactly on cycles where in_valid and in_ready are both 1.
REQ-005 A frame SHALL be, byte order on the wire: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN words; each word is sent high byte first.
REQ-006 The FSM SHALL have states S_ADDR_HI (idle), S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_ERR.
REQ-007 Each byte state SHALL advance to the next state in REQ-005 order on acceptance, and hold otherwise.
REQ-008 in_ready SHALL be 1 in all byte states and in S_ERR, and 0 in S_WRITE.
REQ-009 On LEN_LO acceptance the block SHALL range-check the frame using 17-bit unsigned arithmetic, with the next states:
- ADDR+LEN > N_ELEMENTS: go to S_ERR.
- LEN == 0: go to S_ADDR_HI and pulse done on the next cycle.
- Otherwise: go to S_DATA_HI.

REQ-010 On DATA_LO acceptance the block SHALL latch w_data = {hi_byte, lo_byte} and go to S_WRITE.
REQ-011 In S_WRITE, w_en SHALL be 1 for exactly one cycle, with w_addr = current pointer.
REQ-012 Leaving S_WRITE, the pointer SHALL increment by 1 and the remaining count SHALL decrement by 1.
- If the remaining count reaches 0, the next state SHALL be S_ADDR_HI and done SHALL be 1 for that one cycle.
- Otherwise the next state SHALL be S_DATA_HI.

REQ-013 Write latency SHALL be exactly one cycle from DATA_LO acceptance to the w_en cycle.
REQ-014 The minimum period SHALL be 3 cycles per word with in_valid held high.
REQ-015 w_addr and w_data SHALL hold their last values when w_en = 0, and w_en SHALL never be 1 outside S_WRITE.
REQ-016 busy SHALL be 1 in every state except S_ADDR_HI and S_ERR, and SHALL be 0 on the done cycle.
REQ-017 In S_ERR the block SHALL:
- set err = 1;
- accept and discard all bytes;
- never assert w_en.
Only rst SHALL leave S_ERR.
REQ-018 A pointer wrap past N_ELEMENTS-1 SHALL be impossible by construction (REQ-009); the bench SHALL assert that it never occurs.
REQ-019 A stalled stream (in_valid = 0) SHALL hold the state, pointer, count and all outputs indefinitely, with no timeout.

Reset
REQ-020 On rst = 1 at a clk rising edge, the block SHALL enter S_ADDR_HI and clear:
- pointer, count and byte latches;
- w_addr = 0, w_data = 0;
- w_en = 0, busy = 0, done = 0, err = 0.
REQ-021 During rst, in_ready SHALL be 0.
REQ-022 If rst is asserted mid-frame (including in S_WRITE), the block SHALL abort the frame with no further w_en; words already written SHALL remain in memory.
REQ-023 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-024 Nominal load: stream 00 00 00 03 | 20 12 | 22 12 | F0 00 with in_valid always 1 -> required response:
- w_en pulses writing 0x0000=2012, 0x0001=2212, 0x0002=F000;
- done pulses one cycle after the third write;
- busy falls with done.
REQ-025 Offset and backpressure: ADDR = 0x007E, LEN = 2, with in_valid toggling 1/0 every cycle -> required response:
- writes to 0x7E and 0x7F only;
- in_ready = 0 exactly in the write cycles;
- no byte is dropped or duplicated.
REQ-026 Range error: ADDR = 0x007F, LEN = 2 -> required response:
- err = 1 the cycle after LEN_LO is accepted;
- 4 following bytes are consumed with no w_en;
- err stays 1 until rst.
REQ-027 Zero length: 00 10 00 00 -> required response:
- no w_en;
- done pulses once;
- the next frame loads normally.
REQ-028 Reset mid-frame: assert rst on the cycle DATA_LO of word 2 is accepted (frame ADDR = 0, LEN = 4) -> required response:
- only word 1 is written;
- outputs match their reset values;
- a new frame starting at ADDR_HI succeeds.
